// File: rtl/mixcolumns_serial.sv
// Byte-serial AES MixColumns: a column of 4 bytes in, 4 mixed bytes out, 4 cycles after each input byte.
// No backpressure: a loaded column always drains in 4 consecutive cycles, and a new load on the last drain edge continues without a gap.
module mixcolumns_serial #(
  parameter int COLS_PER_BLOCK = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] inbyte,
  input  logic       enable,
  input  logic       bypass,
  output logic [7:0] outbyte,
  output logic       ready,
  output logic       block_done
);

  localparam int CW = (COLS_PER_BLOCK > 1) ? $clog2(COLS_PER_BLOCK) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS_PER_BLOCK - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [7:0]      a0, a1, a2;
  logic [1:0]      in_cnt;
  logic [1:0]      out_cnt;
  logic [CW-1:0]   col_cnt;
  logic            byp_q;
  logic [3:0][7:0] sr;
  logic [3:0][7:0] mix;
  logic            load;
  logic            last;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  // The fourth byte is used straight off the input, so only three bytes are buffered.
  always_comb begin
    mix = '0;
    if (byp_q) begin
      mix[0] = a0;
      mix[1] = a1;
      mix[2] = a2;
      mix[3] = inbyte;
    end else begin
      mix[0] = xtime(a0) ^ mul3(a1) ^ a2 ^ inbyte;
      mix[1] = a0 ^ xtime(a1) ^ mul3(a2) ^ inbyte;
      mix[2] = a0 ^ a1 ^ xtime(a2) ^ mul3(inbyte);
      mix[3] = mul3(a0) ^ a1 ^ a2 ^ xtime(inbyte);
    end
  end

  always_comb begin
    load    = enable && (in_cnt == 2'd3);
    last    = (state_q == DRAIN) && (out_cnt == 2'd3);
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = DRAIN;
      DRAIN:   if (last && !load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a0     <= '0;
      a1     <= '0;
      a2     <= '0;
      in_cnt <= '0;
      byp_q  <= 1'b0;
    end else if (enable) begin
      case (in_cnt)
        2'd0:    begin a0 <= inbyte; byp_q <= bypass; end
        2'd1:    a1 <= inbyte;
        2'd2:    a2 <= inbyte;
        default: ;
      endcase
      in_cnt <= in_cnt + 2'd1;
    end
  end

  // The head is not shifted on the final drain edge, so outbyte keeps m3 while idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr      <= '0;
      out_cnt <= '0;
    end else if (load) begin
      sr      <= mix;
      out_cnt <= '0;
    end else if (state_q == DRAIN) begin
      if (!last) sr <= {8'h00, sr[3], sr[2], sr[1]};
      out_cnt <= out_cnt + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  col_cnt <= '0;
    else if (last) col_cnt <= (col_cnt == COL_LAST) ? '0 : col_cnt + CW'(1);
  end

  assign outbyte    = sr[0];
  assign ready      = (state_q == DRAIN);
  assign block_done = last && (col_cnt == COL_LAST);

endmodule

// File: tb/tb_mixcolumns_serial.sv
// Directed bench for mixcolumns_serial: hand-computed AES MixColumns vectors, timing, bypass and reset cases.
module tb_mixcolumns_serial;

  logic       clock;
  logic       reset_n;
  logic [7:0] inbyte;
  logic       enable;
  logic       bypass;
  logic [7:0] outbyte;
  logic       ready;
  logic       block_done;

  int n_checks;
  int n_fail;

  mixcolumns_serial #(.COLS_PER_BLOCK(4)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .inbyte(inbyte),
    .enable(enable),
    .bypass(bypass),
    .outbyte(outbyte),
    .ready(ready),
    .block_done(block_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    bypass  = 1'b0;
    inbyte  = 8'h00;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b1;
    inbyte  = 8'hdb;
    bypass  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (ready !== 1'b0 || outbyte !== 8'h00 || block_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state cyc %0d: ready=%b outbyte=%h block_done=%b, need 0/00/0", c, ready, outbyte, block_done);
      end
    end
    enable  = 1'b0;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (ready !== 1'b0 || outbyte !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_release cyc %0d: ready=%b outbyte=%h, need 0/00", c, ready, outbyte);
      end
    end
  endtask

  task automatic test_single_column();
    logic [7:0] din [4];
    logic [7:0] exp [4];
    din = '{8'hdb, 8'h13, 8'h53, 8'h45};
    exp = '{8'h8e, 8'h4d, 8'ha1, 8'hbc};
    do_reset();
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if (ready !== (c >= 4 && c <= 7) || block_done !== 1'b0) begin
        n_fail++;
        $display("FAIL single_timing cyc %0d: ready=%b block_done=%b, need %b/0", c, ready, block_done, (c >= 4 && c <= 7));
      end
      if (c >= 4 && c <= 7) begin
        n_checks++;
        if (outbyte !== exp[c-4]) begin
          n_fail++;
          $display("FAIL single_data cyc %0d: outbyte=%h, need %h", c, outbyte, exp[c-4]);
        end
      end
      if (c == 9) begin
        n_checks++;
        if (outbyte !== 8'hbc) begin
          n_fail++;
          $display("FAIL idle_hold: outbyte=%h, need bc", outbyte);
        end
      end
      enable = (c < 4);
      inbyte = (c < 4) ? din[c] : 8'h00;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] din [16];
    logic [7:0] exp [16];
    din = '{8'hf2, 8'h0a, 8'h22, 8'h5c, 8'h01, 8'h01, 8'h01, 8'h01,
            8'hc6, 8'hc6, 8'hc6, 8'hc6, 8'hd4, 8'hbf, 8'h5d, 8'h30};
    exp = '{8'h9f, 8'hdc, 8'h58, 8'h9d, 8'h01, 8'h01, 8'h01, 8'h01,
            8'hc6, 8'hc6, 8'hc6, 8'hc6, 8'h04, 8'h66, 8'h81, 8'he5};
    do_reset();
    for (int c = 0; c < 23; c++) begin
      n_checks++;
      if (ready !== (c >= 4 && c <= 19) || block_done !== (c == 19)) begin
        n_fail++;
        $display("FAIL b2b_timing cyc %0d: ready=%b block_done=%b, need %b/%b", c, ready, block_done, (c >= 4 && c <= 19), (c == 19));
      end
      if (c >= 4 && c <= 19) begin
        n_checks++;
        if (outbyte !== exp[c-4]) begin
          n_fail++;
          $display("FAIL b2b_data cyc %0d: outbyte=%h, need %h", c, outbyte, exp[c-4]);
        end
      end
      enable = (c < 16);
      inbyte = (c < 16) ? din[c] : 8'h00;
      tick();
    end
  endtask

  task automatic test_gapped_input();
    logic [7:0] din [4];
    logic [7:0] exp [4];
    din = '{8'hd4, 8'hbf, 8'h5d, 8'h30};
    exp = '{8'h04, 8'h66, 8'h81, 8'he5};
    do_reset();
    for (int c = 0; c < 13; c++) begin
      n_checks++;
      if (ready !== (c >= 7 && c <= 10)) begin
        n_fail++;
        $display("FAIL gap_timing cyc %0d: ready=%b, need %b", c, ready, (c >= 7 && c <= 10));
      end
      if (c >= 7 && c <= 10) begin
        n_checks++;
        if (outbyte !== exp[c-7]) begin
          n_fail++;
          $display("FAIL gap_data cyc %0d: outbyte=%h, need %h", c, outbyte, exp[c-7]);
        end
      end
      enable = (c <= 6) && (c % 2 == 0);
      inbyte = enable ? din[c/2] : 8'hee;
      tick();
    end
  endtask

  task automatic test_bypass();
    logic [7:0] din [4];
    logic       byp [4];
    din = '{8'hdb, 8'h13, 8'h53, 8'h45};
    byp = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (ready !== (c >= 4 && c <= 7)) begin
        n_fail++;
        $display("FAIL bypass_timing cyc %0d: ready=%b, need %b", c, ready, (c >= 4 && c <= 7));
      end
      if (c >= 4 && c <= 7) begin
        n_checks++;
        if (outbyte !== din[c-4]) begin
          n_fail++;
          $display("FAIL bypass_data cyc %0d: outbyte=%h, need %h", c, outbyte, din[c-4]);
        end
      end
      enable = (c < 4);
      inbyte = (c < 4) ? din[c] : 8'h00;
      bypass = (c < 4) ? byp[c] : 1'b0;
      tick();
    end
    bypass = 1'b0;
  endtask

  task automatic test_reset_mid_column();
    do_reset();
    enable = 1'b1;
    inbyte = 8'hdb;
    tick();
    inbyte = 8'h13;
    tick();
    enable  = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b0 || outbyte !== 8'h00) begin
      n_fail++;
      $display("FAIL midcol_reset: ready=%b outbyte=%h, need 0/00", ready, outbyte);
    end
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (ready !== (c >= 4 && c <= 7)) begin
        n_fail++;
        $display("FAIL midcol_timing cyc %0d: ready=%b, need %b", c, ready, (c >= 4 && c <= 7));
      end
      if (c >= 4 && c <= 7) begin
        n_checks++;
        if (outbyte !== 8'h01) begin
          n_fail++;
          $display("FAIL midcol_data cyc %0d: outbyte=%h, need 01", c, outbyte);
        end
      end
      enable = (c < 4);
      inbyte = 8'h01;
      tick();
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [7:0] din [4];
    din = '{8'hdb, 8'h13, 8'h53, 8'h45};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      enable = (c < 4);
      inbyte = (c < 4) ? din[c] : 8'h00;
      tick();
    end
    n_checks++;
    if (ready !== 1'b1 || outbyte !== 8'ha1) begin
      n_fail++;
      $display("FAIL drain_pre: ready=%b outbyte=%h, need 1/a1", ready, outbyte);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b0 || outbyte !== 8'h00 || block_done !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_async_reset: ready=%b outbyte=%h, need 0/00", ready, outbyte);
    end
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (ready !== 1'b0 || outbyte !== 8'h00) begin
        n_fail++;
        $display("FAIL drain_after_reset cyc %0d: ready=%b outbyte=%h, need 0/00", c, ready, outbyte);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    enable   = 1'b0;
    bypass   = 1'b0;
    inbyte   = 8'h00;
    test_reset();
    test_single_column();
    test_back_to_back();
    test_gapped_input();
    test_bypass();
    test_reset_mid_column();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
